// File: rtl/axis_vlan_drop_filter.sv
// axis_vlan_drop_filter: AXI-Stream ingress filter that forwards 802.1Q packets whose VID is enabled and drops the rest.
// Ports:
//   clk, aresetn             - clock, asynchronous active-low reset
//   s_axis_*                 - input stream (byte 0 in tdata[7:0]); header parsed on the first beat only
//   m_axis_*                 - output stream through a one-beat register
//   cfg_wr/cfg_vid/cfg_en    - write one bit of the VLAN enable bitmap (VIDs >= NUM_VLAN ignored)
//   cnt_clr                  - synchronous clear of all statistics, wins over increments
//   vlan_en                  - current bitmap
//   pass_pkt_cnt, drop_pkt_cnt, drop_byte_cnt - saturating statistics
module axis_vlan_drop_filter #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_VLAN             = 16,
    parameter logic [NUM_VLAN-1:0] VLAN_EN_RESET = '0,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    input  logic                              cfg_wr,
    input  logic [11:0]                       cfg_vid,
    input  logic                              cfg_en,
    input  logic                              cnt_clr,
    output logic [NUM_VLAN-1:0]               vlan_en,
    output logic [CNT_WIDTH-1:0]              pass_pkt_cnt,
    output logic [CNT_WIDTH-1:0]              drop_pkt_cnt,
    output logic [CNT_WIDTH-1:0]              drop_byte_cnt
);
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int PW = $clog2(KW + 1);
    localparam int SW = (CNT_WIDTH > PW ? CNT_WIDTH : PW) + 1;

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t                          state_q, state_d;
    logic [NUM_VLAN-1:0]             vlan_en_q, vlan_en_d;
    logic [CNT_WIDTH-1:0]            pass_q, pass_d, dpkt_q, dpkt_d, dbyte_q, dbyte_d;
    logic                            m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [C_S_AXIS_DATA_WIDTH-1:0]  m_data_q, m_data_d;
    logic [KW-1:0]                   m_keep_q, m_keep_d;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] m_user_q, m_user_d;

    logic [15:0]   tpid;
    logic [11:0]   vid;
    logic          hit, accept, pass_beat, drop_beat, out_rdy, xfer, first, load;
    logic [PW-1:0] pop;
    logic [SW-1:0] byte_sum;

    always_comb begin
        tpid = {s_axis_tdata[103:96], s_axis_tdata[111:104]};
        vid  = {s_axis_tdata[115:112], s_axis_tdata[127:120]};
        // VIDs at or above NUM_VLAN match no bit and are therefore rejected
        hit = 1'b0;
        for (int i = 0; i < NUM_VLAN; i++) hit = (vid == 12'(i)) ? vlan_en_q[i] : hit;
        accept    = (tpid == 16'h8100) && hit;
        pass_beat = (state_q == PASS) || (state_q == IDLE && accept);
        drop_beat = (state_q == DROP) || (state_q == IDLE && !accept);
        out_rdy   = !m_valid_q || m_axis_tready;
        // dropped beats are sunk unconditionally, independent of the output stage
        s_axis_tready = drop_beat || out_rdy;
        xfer  = s_axis_tvalid && s_axis_tready;
        first = xfer && state_q == IDLE;
        state_d = !xfer ? state_q :
                  s_axis_tlast ? IDLE :
                  state_q == IDLE ? (accept ? PASS : DROP) : state_q;
        for (int i = 0; i < NUM_VLAN; i++)
            vlan_en_d[i] = (cfg_wr && cfg_vid == 12'(i)) ? cfg_en : vlan_en_q[i];
        pop = '0;
        for (int i = 0; i < KW; i++) pop = pop + PW'(s_axis_tkeep[i]);
        byte_sum = SW'(dbyte_q) + SW'(pop);
        pass_d  = cnt_clr ? '0 : (first && accept && !(&pass_q)) ? pass_q + 1'b1 : pass_q;
        dpkt_d  = cnt_clr ? '0 : (first && !accept && !(&dpkt_q)) ? dpkt_q + 1'b1 : dpkt_q;
        dbyte_d = cnt_clr ? '0 :
                  !(xfer && drop_beat) ? dbyte_q :
                  (byte_sum > SW'({CNT_WIDTH{1'b1}})) ? '1 : byte_sum[CNT_WIDTH-1:0];
        load      = out_rdy && xfer && pass_beat;
        m_valid_d = out_rdy ? (xfer && pass_beat) : m_valid_q;
        m_data_d  = load ? s_axis_tdata : m_data_q;
        m_keep_d  = load ? s_axis_tkeep : m_keep_q;
        m_user_d  = load ? s_axis_tuser : m_user_q;
        m_last_d  = load ? s_axis_tlast : m_last_q;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            vlan_en_q <= VLAN_EN_RESET;
            pass_q    <= '0;
            dpkt_q    <= '0;
            dbyte_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_user_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            vlan_en_q <= vlan_en_d;
            pass_q    <= pass_d;
            dpkt_q    <= dpkt_d;
            dbyte_q   <= dbyte_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_user_q  <= m_user_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tlast  = m_last_q;
    assign vlan_en       = vlan_en_q;
    assign pass_pkt_cnt  = pass_q;
    assign drop_pkt_cnt  = dpkt_q;
    assign drop_byte_cnt = dbyte_q;
endmodule

// File: doc/axis_vlan_drop_filter.md
Name: axis_vlan_drop_filter

Overview:
Parametrised AXI-Stream ingress filter that sits in front of the RMT pipeline (ahead of rmt_wrapper). It drops whole packets that are not 802.1Q-tagged or whose VLAN ID is not enabled in a runtime-writable bitmap, and forwards all other packets unchanged through a one-beat output register. It keeps saturating pass/drop packet and drop-byte statistics. These counters make drop behaviour observable in hardware, not only in simulation.

Parameters:
C_S_AXIS_DATA_WIDTH, 512, tdata width in bits (multiple of 128)
C_S_AXIS_TUSER_WIDTH, 128, tuser width, carried through untouched
NUM_VLAN, 16, number of enable bits; VLAN IDs >= NUM_VLAN are always dropped
VLAN_EN_RESET, {NUM_VLAN{1'b0}}, bitmap value after reset
CNT_WIDTH, 32, width of each statistics counter

Ports:
clk  in  1  stream and config clock
aresetn  in  1  asynchronous active-low reset
s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  input data; byte 0 is tdata[7:0]
s_axis_tkeep  in  C_S_AXIS_DATA_WIDTH/8  byte enables
s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  sideband
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last beat of packet
m_axis_tdata  out  C_S_AXIS_DATA_WIDTH  output data
m_axis_tkeep  out  C_S_AXIS_DATA_WIDTH/8  output byte enables
m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH  output sideband
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  output last
cfg_wr  in  1  bitmap write strobe
cfg_vid  in  12  VLAN ID to write
cfg_en  in  1  enable value written
cnt_clr  in  1  synchronous clear of all counters
vlan_en  out  NUM_VLAN  current bitmap
pass_pkt_cnt  out  CNT_WIDTH  forwarded packets
drop_pkt_cnt  out  CNT_WIDTH  dropped packets
drop_byte_cnt  out  CNT_WIDTH  sum of tkeep popcounts of dropped beats

Behaviour:
- Reset, asynchronous: state=IDLE; m_axis_tvalid=0; m_axis_tdata/tkeep/tuser/tlast=0; all counters=0; vlan_en=VLAN_EN_RESET.
- Header parse is done on the first beat only. TPID = {byte12,byte13}. VID = {byte14[3:0],byte15}.
- Accept condition: TPID==16'h8100 && VID<NUM_VLAN && vlan_en[VID]. Otherwise the packet is dropped.
- FSM states: IDLE (awaiting first beat), PASS, DROP.
- IDLE -> PASS on an accepted first beat without tlast. IDLE -> DROP on a rejected first beat without tlast. PASS/DROP -> IDLE on a transferred beat with tlast. A first beat with tlast is a single-beat packet and the FSM stays in IDLE.
- The decision uses vlan_en as registered before the edge. A cfg_wr in the same cycle as a first beat affects the next packet only. A cfg_wr mid-packet never changes the current packet's fate.
- cfg_wr with cfg_vid>=NUM_VLAN is ignored.
- s_axis_tready:
  - =1 in DROP.
  - In IDLE, =1 if the first beat is rejected; otherwise = !m_axis_tvalid || m_axis_tready.
  - In PASS, = !m_axis_tvalid || m_axis_tready.
- Forwarded beats are registered with 1-cycle latency, with data/keep/user/last unmodified. m_axis_tvalid holds, with stable payload, until m_axis_tready. Back-to-back throughput is one beat per cycle when m_axis_tready=1.
- Dropped beats never reach m_axis_*; m_axis_tvalid stays 0 for them.
- Counters:
  - pass_pkt_cnt increments on each accepted first beat.
  - drop_pkt_cnt increments on each rejected first beat.
  - drop_byte_cnt adds popcount(s_axis_tkeep) of every accepted-for-drop beat.
  - All counters saturate at all-ones.
  - cnt_clr has priority over increments in the same cycle.
- Empty cycles (tvalid=0) have no effect on any state or counter.

Test Plan:
1. Reset, then set vlan_en[1]=1. Send a 2-beat packet with TPID 8100, VID 1 -> both beats appear on m_axis, 1 cycle later each, identical tdata/tkeep/tlast; pass_pkt_cnt=1.
2. Send a 1-beat packet with VID 1, bitmap all-zero, tkeep=64'hffffffffffffffff -> m_axis_tvalid stays 0 for 300 cycles; drop_pkt_cnt=1, drop_byte_cnt=64.
3. Send an untagged packet (TPID 0800) and one with VID=20 (>=NUM_VLAN) -> both dropped; drop_pkt_cnt=2; s_axis_tready=1 throughout.
4. Send a 3-beat VID 1 packet while holding m_axis_tready=0 for 5 cycles -> s_axis_tready=0 after the first beat, output payload stable, no beat lost or duplicated after release.
5. Issue cfg_wr(vid=1, en=0) during the 2nd beat of a passing VID 1 packet -> the current packet completes on m_axis; the next VID 1 packet is dropped.
6. Preset drop_byte_cnt near saturation (CNT_WIDTH=8), drop 64-byte beats -> counter sticks at 8'hff. Assert cnt_clr together with a drop -> counter reads 0. Assert aresetn low mid-packet -> m_axis_tvalid=0 and state=IDLE immediately.
